// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
//   FWD_*       : encodings of the EX operand forwarding selects
//   slot_t      : one in-flight destination record {valid, addr, load}
//   slot_match  : true when an in-flight slot supplies a register the ID
//                 instruction actually reads
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic       load;
  } slot_t;

  // Slots with addr 0 are never marked valid, so r0 can never match here.
  function automatic logic slot_match(input slot_t slot, input logic [4:0] reg_idx,
                                      input logic uses);
    return uses && slot.valid && (slot.addr == reg_idx);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-stage destination scoreboard (ex -> mem -> wb).
//   clk, reset : pipeline clock, synchronous active-high reset
//   issue      : the ID instruction enters EX this cycle
//   in_slot    : record of the ID instruction's destination
//   ex_slot, mem_slot, wb_slot : current contents of the three slots
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  issue,
  input  slot_t in_slot,
  output slot_t ex_slot,
  output slot_t mem_slot,
  output slot_t wb_slot
);

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;

  always_comb begin
    ex_d  = '0;
    if (issue) ex_d = in_slot;
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_slot  = ex_q;
  assign mem_slot = mem_q;
  assign wb_slot  = wb_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline.
//   clk, reset        : pipeline clock, synchronous active-high reset
//   id_rs/id_rt       : source fields of the ID instruction (+ id_uses_rs/rt)
//   id_regwr/id_addrc : ID instruction writes register id_addrc
//   id_memrd          : ID instruction is a load
//   id_jump           : jump resolved in ID
//   ex_br_taken       : branch in EX resolved taken
//   stall, ifid_hold  : load-use bubble into ID/EX, hold PC and IF/ID
//   ifid_flush        : zero IF/ID on the next edge
//   fwd_a, fwd_b      : registered EX operand forwarding selects
//   stall_cnt, flush_cnt : saturating debug event counters
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwr,
  input  logic [4:0]       id_addrc,
  input  logic             id_memrd,
  input  logic             id_jump,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  slot_t ex_slot, mem_slot, wb_slot;
  slot_t id_slot;
  logic  issue;
  logic  rs_ex, rt_ex, rs_mem, rt_mem;

  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // The WB slot and the load bit past EX are tracked but no logic here reads them.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_slot.load, wb_slot};

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .in_slot  (id_slot),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot)
  );

  always_comb begin
    rs_ex  = slot_match(ex_slot,  id_rs, id_uses_rs);
    rt_ex  = slot_match(ex_slot,  id_rt, id_uses_rt);
    rs_mem = slot_match(mem_slot, id_rs, id_uses_rs);
    rt_mem = slot_match(mem_slot, id_rt, id_uses_rt);

    // A taken branch kills the ID instruction, so it can never cause a stall.
    stall      = !ex_br_taken && ex_slot.load && (rs_ex || rt_ex);
    ifid_hold  = stall;
    issue      = !stall && !ex_br_taken;
    // A stalled jump is re-presented next cycle, so its flush waits too.
    ifid_flush = ex_br_taken || (id_jump && !stall);

    id_slot.valid = id_regwr && (id_addrc != 5'd0);
    id_slot.addr  = id_addrc;
    id_slot.load  = id_memrd;

    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (issue) begin
      if (rs_ex)       fwd_a_d = FWD_EXMEM;
      else if (rs_mem) fwd_a_d = FWD_MEMWB;
      if (rt_ex)       fwd_b_d = FWD_EXMEM;
      else if (rt_mem) fwd_b_d = FWD_MEMWB;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Inputs change on the falling edge; outputs are checked before the next rising edge.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SAT = '1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, id_addrc;
  logic             id_uses_rs, id_uses_rt, id_regwr, id_memrd, id_jump, ex_br_taken;
  logic             stall, ifid_hold, ifid_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_regwr    (id_regwr),
    .id_addrc    (id_addrc),
    .id_memrd    (id_memrd),
    .id_jump     (id_jump),
    .ex_br_taken (ex_br_taken),
    .stall       (stall),
    .ifid_hold   (ifid_hold),
    .ifid_flush  (ifid_flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one ID instruction: sources (with use flags), destination, load flag.
  task automatic id_ins(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic wr, input logic [4:0] rd,
                        input logic ld);
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_regwr = wr; id_addrc = rd; id_memrd = ld;
    id_jump = 1'b0; ex_br_taken = 1'b0;
  endtask

  task automatic idle();
    id_ins(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_hold", ifid_hold, 0);
    chk("rst_flush", ifid_flush, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 0);

    // Load-use: lw r8,0(r29) ; add r9,r8,r1
    id_ins(5'd29, 1, 5'd8, 0, 1, 5'd8, 1);
    #1 chk("lu_no_stall_on_load", stall, 0);
    @(negedge clk);
    id_ins(5'd8, 1, 5'd1, 1, 1, 5'd9, 0);
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_hold", ifid_hold, 1);
    chk("lu_flush", ifid_flush, 0);
    @(negedge clk);
    #1;
    chk("lu_stall_one_cycle", stall, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_fwd_a_bubble", fwd_a, 0);
    @(negedge clk);
    chk("lu_fwd_a_memwb", fwd_a, 2);
    chk("lu_fwd_b", fwd_b, 0);

    // ALU dependence: addi r5,r1 ; sub r6,r1,r5
    id_ins(5'd1, 1, 5'd0, 0, 1, 5'd5, 0);
    @(negedge clk);
    id_ins(5'd1, 1, 5'd5, 1, 1, 5'd6, 0);
    #1 chk("alu_no_stall", stall, 0);
    @(negedge clk);
    chk("alu_fwd_b_exmem", fwd_b, 1);
    chk("alu_fwd_a", fwd_a, 0);

    // Double writer: addi r5 ; addi r5 ; or r7,r5,r3
    id_ins(5'd2, 1, 5'd0, 0, 1, 5'd5, 0);
    @(negedge clk);
    @(negedge clk);
    id_ins(5'd5, 1, 5'd3, 1, 1, 5'd7, 0);
    @(negedge clk);
    chk("dbl_fwd_a_priority", fwd_a, 1);
    chk("dbl_fwd_b", fwd_b, 0);

    // r0 writer (a load, so a bogus match would also stall)
    id_ins(5'd1, 1, 5'd0, 0, 1, 5'd0, 1);
    @(negedge clk);
    id_ins(5'd0, 1, 5'd0, 1, 1, 5'd10, 0);
    #1 chk("r0_no_stall", stall, 0);
    @(negedge clk);
    chk("r0_fwd_a", fwd_a, 0);
    chk("r0_fwd_b", fwd_b, 0);

    // Taken branch in the same cycle as a load-use match
    id_ins(5'd29, 1, 5'd8, 0, 1, 5'd8, 1);
    @(negedge clk);
    id_ins(5'd8, 1, 5'd1, 1, 1, 5'd9, 0);
    ex_br_taken = 1'b1;
    #1;
    chk("br_no_stall", stall, 0);
    chk("br_flush", ifid_flush, 1);
    chk("br_no_hold", ifid_hold, 0);
    @(negedge clk);
    ex_br_taken = 1'b0;
    #1;
    chk("br_ex_bubble_no_stall", stall, 0);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt_unchanged", stall_cnt, 1);
    @(negedge clk);
    chk("br_after_fwd_a", fwd_a, 2);

    // Jump together with a load-use stall, then the re-presented jump
    id_ins(5'd29, 1, 5'd8, 0, 1, 5'd8, 1);
    @(negedge clk);
    id_ins(5'd8, 1, 5'd1, 1, 1, 5'd9, 0);
    id_jump = 1'b1;
    #1;
    chk("jmp_stall_wins", stall, 1);
    chk("jmp_no_flush_stalled", ifid_flush, 0);
    @(negedge clk);
    #1;
    chk("jmp_no_stall", stall, 0);
    chk("jmp_flush", ifid_flush, 1);
    chk("jmp_stall_cnt", stall_cnt, 2);
    @(negedge clk);
    chk("jmp_flush_cnt", flush_cnt, 2);
    idle();

    // Reset asserted during a stall
    id_ins(5'd29, 1, 5'd8, 0, 1, 5'd8, 1);
    @(negedge clk);
    id_ins(5'd8, 1, 5'd1, 1, 1, 5'd9, 0);
    #1 chk("rs_stall_before", stall, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rs_stall_dropped", stall, 0);
    chk("rs_hold", ifid_hold, 0);
    chk("rs_flush", ifid_flush, 0);
    chk("rs_fwd_a", fwd_a, 0);
    chk("rs_fwd_b", fwd_b, 0);
    chk("rs_stall_cnt", stall_cnt, 0);
    chk("rs_flush_cnt", flush_cnt, 0);

    // Saturation: lw r8,0(r8) repeated stalls every other cycle (20 stalls in 40 cycles)
    id_ins(5'd8, 1, 5'd0, 0, 1, 5'd8, 1);
    repeat (40) @(negedge clk);
    chk("sat_stall_cnt", stall_cnt, SAT);
    idle();
    id_jump = 1'b1;
    repeat (20) @(negedge clk);
    chk("sat_flush_cnt", flush_cnt, SAT);
    chk("sat_stall_cnt_hold", stall_cnt, SAT);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
